// File: rtl/hdmi_timing_gen_if.sv
// Pixel-domain raster interface: the timing generator (master) drives coordinates and
// strobes; the consumer (slave) supplies the pixel enable.
interface hdmi_timing_gen_if;
    logic       en;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [9:0] screen_width;
    logic [9:0] screen_height;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  en,
        output cx, cy, screen_width, screen_height,
        output hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        output en,
        input  cx, cy, screen_width, screen_height,
        input  hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: free-running (h,v) pixel counters gated by en, with every
// output registered from the decode of (h,v) so all strobes describe the same pixel.
module hdmi_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  aresetn,
    hdmi_timing_gen_if.master     tif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("hdmi_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [9:0] cx_q, cx_d, cy_q, cy_d;
    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_in_sync, v_in_sync;

    assign h_in_sync = (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
    assign v_in_sync = (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        // With en low everything, including the pulses, holds its value.
        if (tif.en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            cx_d          = h_q;
            cy_d          = v_q;
            de_d          = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
            hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            // v_q only moves on the h wrap, so vsync flips exactly when cx becomes 0.
            vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (h_q == 10'd0);
            frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            h_q           <= '0;
            v_q           <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tif.cx            = cx_q;
    assign tif.cy            = cy_q;
    assign tif.de            = de_q;
    assign tif.hsync         = hsync_q;
    assign tif.vsync         = vsync_q;
    assign tif.line_start    = line_start_q;
    assign tif.frame_start   = frame_start_q;
    assign tif.screen_width  = 10'(H_ACTIVE);
    assign tif.screen_height = 10'(V_ACTIVE);
endmodule
